// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stage indices, stall encodings
// and the flush sequencer state type.
package pipe_ctrl_pkg;

  localparam int NUM_STAGES = 6;
  localparam int NUM_REQ    = 4;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/pipe_stall_encoder.sv
// Combinational prefix encoder: the highest requesting stage k stalls
// every stage from PC up to k+1, so the stalled region is always contiguous.
module pipe_stall_encoder
  import pipe_ctrl_pkg::*;
(
  input  logic [NUM_REQ-1:0]    stall_req,
  output logic [NUM_STAGES-1:0] stall
);

  // Request index k lives at stall bit k+1, so bit j stops when any k >= j-1 requests.
  always_comb begin
    stall = '0;
    for (int j = 0; j < NUM_STAGES; j++) begin
      stall[j] = NO_STOP;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (stall_req[k] && (j <= k + 1)) begin
          stall[j] = STOP;
        end
      end
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline controller: stall merging, exception/ERET flush sequencing and PC redirect.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR   = ADDR_WIDTH'(32'hBFC00380),
  parameter int                    FLUSH_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    stall_req,
  input  logic                  exc_req,
  input  logic                  exc_is_eret,
  input  logic [ADDR_WIDTH-1:0] epc_in,
  output logic [NUM_STAGES-1:0] stall,
  output logic                  flush,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt
);

  localparam int              CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  ctrl_state_t           state, state_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic                  redirect_valid_next;
  logic [ADDR_WIDTH-1:0] redirect_pc_next;
  logic [NUM_STAGES-1:0] enc_stall;

  pipe_stall_encoder u_stall_encoder (
    .stall_req (stall_req),
    .stall     (enc_stall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_RUN;
      cnt            <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      redirect_valid <= redirect_valid_next;
      redirect_pc    <= redirect_pc_next;
    end
  end

  // Exceptions are only accepted in RUN; during FLUSH the younger instructions are already dead.
  always_comb begin
    state_next          = state;
    cnt_next            = cnt;
    redirect_valid_next = 1'b0;
    redirect_pc_next    = redirect_pc;
    flush               = 1'b0;
    stall               = enc_stall;
    case (state)
      ST_RUN: begin
        if (exc_req) begin
          state_next          = ST_FLUSH;
          cnt_next            = CNT_LOAD;
          redirect_valid_next = 1'b1;
          redirect_pc_next    = exc_is_eret ? epc_in : EXC_VECTOR;
        end
      end
      ST_FLUSH: begin
        flush = 1'b1;
        stall = '0;
        if (cnt == '0) begin
          state_next = ST_RUN;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;
  logic        enter_flush;

  assign enter_flush = (state == ST_RUN) && exc_req;

  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall[STG_PC] == STOP) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (enter_flush) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: table-driven stall encoding plus
// hand-written flush, ERET, reset-during-flush and perf counter sequences.
module tb_pipeline_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  stall_req;
  logic        exc_req;
  logic        exc_is_eret;
  logic [31:0] epc_in;

  logic [5:0]  stall, stall_3;
  logic        flush, flush_3;
  logic        redirect_valid, redirect_valid_3;
  logic [31:0] redirect_pc, redirect_pc_3;
  logic [31:0] perf_stall_cnt, perf_stall_cnt_3;
  logic [31:0] perf_flush_cnt, perf_flush_cnt_3;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [3:0] req;
    logic [5:0] exp_stall;
  } stall_vec_t;

  stall_vec_t vecs [9];

  logic [31:0] exp_perf_stall;
  logic [31:0] exp_perf_flush;

  pipeline_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .stall_req      (stall_req),
    .exc_req        (exc_req),
    .exc_is_eret    (exc_is_eret),
    .epc_in         (epc_in),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  pipeline_ctrl #(.FLUSH_CYCLES(3)) dut3 (
    .clk            (clk),
    .rst            (rst),
    .stall_req      (stall_req),
    .exc_req        (exc_req),
    .exc_is_eret    (exc_is_eret),
    .epc_in         (epc_in),
    .stall          (stall_3),
    .flush          (flush_3),
    .redirect_valid (redirect_valid_3),
    .redirect_pc    (redirect_pc_3),
    .perf_stall_cnt (perf_stall_cnt_3),
    .perf_flush_cnt (perf_flush_cnt_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] req, input logic exc,
                               input logic eret, input logic [31:0] epc);
    stall_req   = req;
    exc_req     = exc;
    exc_is_eret = eret;
    epc_in      = epc;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    vecs[0] = '{4'b0000, 6'b000000};
    vecs[1] = '{4'b0001, 6'b000011};
    vecs[2] = '{4'b0010, 6'b000111};
    vecs[3] = '{4'b0100, 6'b001111};
    vecs[4] = '{4'b1000, 6'b011111};
    vecs[5] = '{4'b1001, 6'b011111};
    vecs[6] = '{4'b0110, 6'b001111};
    vecs[7] = '{4'b0011, 6'b000111};
    vecs[8] = '{4'b1111, 6'b011111};

    // Reset state
    rst = 1'b1;
    applyStimulus(4'b0000, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    checkOutput("rst_flush", {31'd0, flush}, 32'd0);
    checkOutput("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    checkOutput("rst_redirect_pc", redirect_pc, 32'd0);
    checkOutput("rst_perf_stall", perf_stall_cnt, 32'd0);
    checkOutput("rst_perf_flush", perf_flush_cnt, 32'd0);
    rst = 1'b0;
    applyStimulus(4'b0100, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("post_rst_stall", {26'd0, stall}, 32'b001111);
    tick();

    // Stall encoder table
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].req, 1'b0, 1'b0, 32'h0);
      #1;
      checkOutput($sformatf("stall_tbl[%0d]", i), {26'd0, stall}, {26'd0, vecs[i].exp_stall});
      tick();
    end

    // Exception, FLUSH_CYCLES=1
    applyStimulus(4'b0000, 1'b1, 1'b0, 32'h1234_5678);
    #1;
    checkOutput("exc_same_cycle_flush", {31'd0, flush}, 32'd0);
    tick();
    applyStimulus(4'b0000, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("exc_n1_flush", {31'd0, flush}, 32'd1);
    checkOutput("exc_n1_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    checkOutput("exc_n1_redirect_pc", redirect_pc, 32'hBFC0_0380);
    checkOutput("exc_n1_stall", {26'd0, stall}, 32'd0);
    tick();
    checkOutput("exc_n2_flush", {31'd0, flush}, 32'd0);
    checkOutput("exc_n2_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    checkOutput("exc_n2_redirect_pc_hold", redirect_pc, 32'hBFC0_0380);

    // Exception beats stall, then reset in the first FLUSH cycle
    applyStimulus(4'b1000, 1'b1, 1'b1, 32'h0000_4000);
    #1;
    checkOutput("exc_stall_same_cycle", {26'd0, stall}, 32'b011111);
    tick();
    applyStimulus(4'b1000, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("exc_stall_flush", {31'd0, flush}, 32'd1);
    checkOutput("exc_stall_forced_zero", {26'd0, stall}, 32'd0);
    checkOutput("exc_stall_redirect_pc", redirect_pc, 32'h0000_4000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checkOutput("midflush_rst_flush", {31'd0, flush}, 32'd0);
    checkOutput("midflush_rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    checkOutput("midflush_rst_redirect_pc", redirect_pc, 32'd0);
    checkOutput("midflush_rst_stall", {26'd0, stall}, 32'b011111);
    checkOutput("midflush_rst_flush_3", {31'd0, flush_3}, 32'd0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 32'h0);
    tick();

    // ERET with FLUSH_CYCLES=3; a second exc_req inside the flush is ignored
    applyStimulus(4'b0000, 1'b1, 1'b1, 32'h8000_1000);
    tick();
    applyStimulus(4'b0000, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("eret_c1_flush", {31'd0, flush_3}, 32'd1);
    checkOutput("eret_c1_redirect_valid", {31'd0, redirect_valid_3}, 32'd1);
    checkOutput("eret_c1_redirect_pc", redirect_pc_3, 32'h8000_1000);
    tick();
    applyStimulus(4'b1000, 1'b1, 1'b0, 32'h1234_5678);
    #1;
    checkOutput("eret_c2_flush", {31'd0, flush_3}, 32'd1);
    checkOutput("eret_c2_redirect_valid", {31'd0, redirect_valid_3}, 32'd0);
    checkOutput("eret_c2_stall_override", {26'd0, stall_3}, 32'd0);
    tick();
    applyStimulus(4'b1000, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("eret_c3_flush", {31'd0, flush_3}, 32'd1);
    checkOutput("eret_c3_redirect_valid", {31'd0, redirect_valid_3}, 32'd0);
    checkOutput("eret_c3_redirect_pc", redirect_pc_3, 32'h8000_1000);
    tick();
    checkOutput("eret_c4_flush", {31'd0, flush_3}, 32'd0);
    checkOutput("eret_c4_redirect_valid", {31'd0, redirect_valid_3}, 32'd0);
    checkOutput("eret_c4_stall", {26'd0, stall_3}, 32'b011111);
    applyStimulus(4'b0000, 1'b0, 1'b0, 32'h0);

    // Perf counters: 5 stalled cycles and 2 exceptions
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("perf_clr_stall", perf_stall_cnt, 32'd0);
    checkOutput("perf_clr_flush", perf_flush_cnt, 32'd0);
    applyStimulus(4'b0001, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    applyStimulus(4'b0000, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(4'b0000, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(4'b0000, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(4'b0000, 1'b0, 1'b0, 32'h0);
    tick();
`ifdef PIPE_CTRL_PERF_EN
    exp_perf_stall = 32'd5;
    exp_perf_flush = 32'd2;
`else
    exp_perf_stall = 32'd0;
    exp_perf_flush = 32'd0;
`endif
    checkOutput("perf_stall_cnt", perf_stall_cnt, exp_perf_stall);
    checkOutput("perf_flush_cnt", perf_flush_cnt, exp_perf_flush);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
